// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-channel round-robin stream arbiter.
package rr_arb_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    // Channel index increment; the 2-bit width gives the mod-4 wrap for free.
    function automatic ch_idx_t next_idx(input ch_idx_t idx);
        return ch_idx_t'(idx + ch_idx_t'(1));
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first requester after last_ptr, wrapping mod 4.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [3:0] in_valid,
    input  ch_idx_t    last_ptr,
    output ch_idx_t    grant,
    output logic       any_req
);

    // The channel at last_ptr is visited last, so the previous winner has lowest priority.
    always_comb begin
        ch_idx_t idx;
        logic    found;
        grant   = '0;
        any_req = |in_valid;
        found   = 1'b0;
        idx     = last_ptr;
        for (int k = 0; k < N_CH; k++) begin
            idx = next_idx(idx);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arb_4.sv
// Four-channel round-robin stream arbiter with a registered valid/ready output stage.
module rr_stream_arb_4
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    ch_idx_t          out_sel_q, out_sel_d;
    ch_idx_t          last_ptr_q, last_ptr_d;

    ch_idx_t          grant;
    logic             any_req;
    logic             load_en;
    logic [WIDTH-1:0] sel_data;

    rr_pick_4 u_pick (
        .in_valid (in_valid),
        .last_ptr (last_ptr_q),
        .grant    (grant),
        .any_req  (any_req)
    );

    always_comb begin
        sel_data = in_data0;
        case (grant)
            2'd0: sel_data = in_data0;
            2'd1: sel_data = in_data1;
            2'd2: sel_data = in_data2;
            2'd3: sel_data = in_data3;
            default: sel_data = in_data0;
        endcase
    end

    // The register can take a new word when empty or when its word leaves this cycle.
    always_comb begin
        load_en     = !out_valid_q || out_ready;
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_ptr_d  = last_ptr_q;
        if (load_en) begin
            if (any_req) begin
                in_ready[grant] = !rst;
                out_valid_d     = 1'b1;
                out_data_d      = sel_data;
                out_sel_d       = grant;
                last_ptr_d      = grant;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_ptr_q  <= ch_idx_t'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_arb_4.sv
// Directed self-checking bench for rr_stream_arb_4 with hand-computed expectations.
module tb_rr_stream_arb_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int checks   = 0;
    int failures = 0;

    rr_stream_arb_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives inputs just after a rising edge, then lets combinational paths settle.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic ordy);
        rst       = r;
        in_valid  = v;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, "_data"},  32'(out_data),  32'(d));
        checkOutput({tag, "_sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        in_data0 = 4'hA;
        in_data1 = 4'hB;
        in_data2 = 4'hC;
        in_data3 = 4'hD;

        // Reset then idle
        applyStimulus(1'b1, 4'b0000, 1'b0);
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        checkRegs("rst", 1'b0, 4'h0, 2'd0);

        // Full contention rotates 0,1,2,3 twice
        applyStimulus(1'b0, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rr_in_ready%0d", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            checkRegs($sformatf("rr%0d", k), 1'b1, 4'(4'hA + k % 4), 2'(k % 4));
        end

        // Two more loads to land on out_sel=1
        tick();
        tick();
        checkRegs("pre_bp", 1'b1, 4'hB, 2'd1);

        // Backpressure holds word and blocks inputs
        applyStimulus(1'b0, 4'b1111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'h0);
            tick();
            checkRegs($sformatf("bp%0d", k), 1'b1, 4'hB, 2'd1);
        end
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'(4'b0100));
        tick();
        checkRegs("bp_release", 1'b1, 4'hC, 2'd2);

        // Sparse: wrap past 3,0 to channel 1, then 3 beats 1 from last=1
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("sparse1_in_ready", 32'(in_ready), 32'(4'b0010));
        tick();
        checkRegs("sparse1", 1'b1, 4'hB, 2'd1);
        applyStimulus(1'b0, 4'b1010, 1'b1);
        checkOutput("sparse2_in_ready", 32'(in_ready), 32'(4'b1000));
        tick();
        checkRegs("sparse2", 1'b1, 4'hD, 2'd3);

        // Empty drain
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("drain_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkRegs("drain", 1'b0, 4'hD, 2'd3);

        // Single requester granted repeatedly, including right after its own grant
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("single0_in_ready", 32'(in_ready), 32'(4'b0001));
        tick();
        checkRegs("single0", 1'b1, 4'hA, 2'd0);
        checkOutput("single1_in_ready", 32'(in_ready), 32'(4'b0001));
        tick();
        checkRegs("single1", 1'b1, 4'hA, 2'd0);

        // Set up out_sel=2 then reset mid-operation
        applyStimulus(1'b0, 4'b0100, 1'b1);
        tick();
        checkRegs("pre_rst", 1'b1, 4'hC, 2'd2);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkRegs("midrst", 1'b0, 4'h0, 2'd0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("postrst_in_ready", 32'(in_ready), 32'(4'b0001));
        tick();
        checkRegs("postrst", 1'b1, 4'hA, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
